// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared defaults and types for the register-file slice.
//   DATA_W   : default register / data-port width in bits
//   ADDR_W   : default address width
//   NUM_REGS : register count implied by ADDR_W (2**ADDR_W)
//   addr_t   : address type at the default width
//   data_t   : data type at the default width
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_example_if.sv
// -----------------------------------------------------------------------------
// reg_file_example_if
// Bundle of the register-file access signals (two read ports, one write port).
// Ports: none (signal container). Modports:
//   master : drives the addresses, write data and strobe; observes read data
//   slave  : the register file side
// The register file keeps flat ports so it can still be instantiated
// positionally. This bundle lets an agent carry the signals as one object.
// -----------------------------------------------------------------------------
interface reg_file_example_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
);

  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] data_in;
  logic              write_enable;
  logic [DATA_W-1:0] data_out1;
  logic [DATA_W-1:0] data_out2;

  modport master (
    output ra1,
    output ra2,
    output wa,
    output data_in,
    output write_enable,
    input  data_out1,
    input  data_out2
  );

  modport slave (
    input  ra1,
    input  ra2,
    input  wa,
    input  data_in,
    input  write_enable,
    output data_out1,
    output data_out2
  );

endinterface : reg_file_example_if

// File: rtl/reg_file_example.sv
// -----------------------------------------------------------------------------
// reg_file_example
// NUM_REGS x DATA_W register file. It has two combinational read ports and one
// synchronous write port.
// Ports (in positional order):
//   RA1, RA2     : read addresses for data_out1 / data_out2
//   WA           : write address
//   data_in      : write data
//   clk          : clock. Writes happen on the rising edge.
//   reset        : asynchronous active-low clear of every register
//   write_enable : active-high write strobe
//   data_out1/2  : reg[RA1] / reg[RA2], with zero latency
// -----------------------------------------------------------------------------
module reg_file_example #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              we_s;

  // The strobe compares against 1'b1 so that an unknown strobe is not
  // treated as a write in simulation.
  assign we_s = (write_enable == 1'b1);

  // Storage: reset clears the whole array. Otherwise, only the addressed
  // register loads when the strobe is active.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_r <= '{default: '0};
    end else if (we_s) begin
      regs_r[WA] <= data_in;
    end
  end

  // The read ports are plain muxes with no write-through bypass. A same-address
  // write becomes visible only after the edge. Every address is in range
  // because NUM_REGS = 2**ADDR_W.
  assign data_out1 = regs_r[RA1];
  assign data_out2 = regs_r[RA2];

endmodule : reg_file_example

// File: tb/tb_reg_file_example.sv
// -----------------------------------------------------------------------------
// tb_reg_file_example
// Directed self-checking bench for reg_file_example. It has no ports.
// -----------------------------------------------------------------------------
module tb_reg_file_example;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  reg_file_example_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  reg_file_example #(.DATA_W(8), .ADDR_W(4)) dut (
    .RA1          (bus.ra1),
    .RA2          (bus.ra2),
    .WA           (bus.wa),
    .data_in      (bus.data_in),
    .clk          (clk),
    .reset        (reset),
    .write_enable (bus.write_enable),
    .data_out1    (bus.data_out1),
    .data_out2    (bus.data_out2)
  );

  // Free-running clock with a 10-unit period. Rising edges occur at 5, 15, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", tag, obs, exp);
    end
  endtask

  // Drive one write at the falling edge, let a rising edge take it, then drop
  // the strobe.
  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.wa           = a;
    bus.data_in      = d;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
  endtask

  task automatic read_pair(input logic [3:0] a1, input logic [3:0] a2);
    bus.ra1 = a1;
    bus.ra2 = a2;
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    n_vec = 0;
    n_err = 0;
    reset            = 1'b0;
    bus.ra1          = 4'd3;
    bus.ra2          = 4'd9;
    bus.wa           = 4'd0;
    bus.data_in      = 8'h00;
    bus.write_enable = 1'b0;

    // The outputs read zero while reset is held, before any clock edge.
    #2;
    chk("reset_out1", bus.data_out1, 8'h00);
    chk("reset_out2", bus.data_out2, 8'h00);

    @(negedge clk);
    reset = 1'b1;

    // Basic write, then read on both ports.
    write_reg(4'd10, 8'h03);
    read_pair(4'd10, 4'd2);
    chk("wr10_out1", bus.data_out1, 8'h03);
    chk("rd2_out2", bus.data_out2, 8'h00);

    // With the strobe low, a clock edge writes nothing.
    @(negedge clk);
    bus.wa = 4'd12;
    bus.data_in = 8'h24;
    bus.write_enable = 1'b0;
    @(posedge clk);
    #1;
    read_pair(4'd12, 4'd10);
    chk("nowr12_out1", bus.data_out1, 8'h00);
    chk("hold10_out2", bus.data_out2, 8'h03);

    // Write the top address and read it on both ports with the same address.
    write_reg(4'd15, 8'hF1);
    read_pair(4'd15, 4'd15);
    chk("same15_out1", bus.data_out1, 8'hF1);
    chk("same15_out2", bus.data_out2, 8'hF1);
    read_pair(4'd10, 4'd15);
    chk("still10_out1", bus.data_out1, 8'h03);

    // Read during a write to the same address: the old value shows before the
    // edge and the new value after it.
    @(negedge clk);
    bus.ra1 = 4'd5;
    bus.wa = 4'd5;
    bus.data_in = 8'hAA;
    bus.write_enable = 1'b1;
    #1;
    chk("rdw5_before", bus.data_out1, 8'h00);
    @(posedge clk);
    #1;
    chk("rdw5_after", bus.data_out1, 8'hAA);
    bus.write_enable = 1'b0;

    // Fill every register with {a, ~a} and read them back in crossed pairs.
    for (int i = 0; i < 16; i++) begin
      pat = {i[3:0], ~i[3:0]};
      write_reg(i[3:0], pat);
    end
    for (int i = 0; i < 16; i++) begin
      logic [3:0] j;
      j = 4'(15 - i);
      read_pair(i[3:0], j);
      chk($sformatf("fill_out1_%0d", i), bus.data_out1, {i[3:0], ~i[3:0]});
      chk($sformatf("fill_out2_%0d", i), bus.data_out2, {j, ~j});
    end

    // Assert reset between edges. The outputs clear at once, and a strobed
    // edge during reset writes nothing.
    read_pair(4'd3, 4'd12);
    chk("pre_rst_out1", bus.data_out1, 8'h3C);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out1", bus.data_out1, 8'h00);
    chk("mid_rst_out2", bus.data_out2, 8'h00);
    bus.wa = 4'd3;
    bus.data_in = 8'h5A;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_blocks_wr", bus.data_out1, 8'h00);
    @(negedge clk);
    bus.write_enable = 1'b0;
    reset = 1'b1;

    // After reset is released, every register reads zero.
    for (int i = 0; i < 16; i += 2) begin
      read_pair(i[3:0], 4'(i + 1));
      chk($sformatf("post_rst_%0d", i), bus.data_out1, 8'h00);
      chk($sformatf("post_rst_%0d", i + 1), bus.data_out2, 8'h00);
    end

    // The first write after reset release takes effect on the next edge.
    write_reg(4'd7, 8'h77);
    read_pair(4'd7, 4'd6);
    chk("first_wr7", bus.data_out1, 8'h77);
    chk("first_wr6", bus.data_out2, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_reg_file_example

// File: doc/reg_file_example.md
REG_FILE_EXAMPLE -- requirements
Module: reg_file_example

Interface
REQ-001 Parameter: DATA_W, default 8, register and data-port width in bits.
REQ-002 Parameter: ADDR_W, default 4, address width; register count NUM_REGS = 2**ADDR_W (16).
REQ-003 Port order SHALL be exactly: RA1, RA2, WA, data_in, clk, reset, write_enable, data_out1, data_out2 (positional instantiation is supported).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 RA1  input  ADDR_W  read address, port 1.
REQ-007 RA2  input  ADDR_W  read address, port 2.
REQ-008 WA  input  ADDR_W  write address.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 write_enable  input  1  active-high write strobe, sampled on rising clk.
REQ-011 data_out1  output  DATA_W  contents of register RA1.
REQ-012 data_out2  output  DATA_W  contents of register RA2.

Function
REQ-013 Storage SHALL be NUM_REGS registers of DATA_W bits, all individually addressable; no register is hardwired.
REQ-014 Reads SHALL be combinational: data_out1 = reg[RA1], data_out2 = reg[RA2], zero clock latency, updating on any address or register change.
REQ-015 Both read ports SHALL be independent; RA1 == RA2 returns the same value on both outputs.
REQ-016 On a rising clk with reset = 1 and write_enable = 1, reg[WA] SHALL load data_in; all other registers hold.
REQ-017 With write_enable = 0, no register SHALL change on the clock edge, regardless of WA or data_in.
REQ-018 Read-during-write to the same address: output shows the old value before the edge and the new value immediately after; no write-through bypass.
REQ-019 Exactly one write per cycle; all WA values 0..NUM_REGS-1 are valid (no out-of-range case).
REQ-020 X/unknown write_enable SHALL NOT be treated as a write in simulation-intent RTL (use explicit == 1'b1 check).

Reset
REQ-021 While reset = 0, all registers SHALL be cleared to 0 immediately (asynchronously), so data_out1 = data_out2 = 0.
REQ-022 Reset SHALL override write_enable; no write occurs on any edge while reset = 0.
REQ-023 Reset asserted mid-operation SHALL clear previously written data; first write after deassertion takes effect on the next rising clk with reset = 1.

Structure
REQ-024 A shared package reg_file_pkg SHALL hold DATA_W, ADDR_W and NUM_REGS defaults and address/data typedefs (addr_t, data_t).
REQ-025 Single flat module; no sub-module is required (storage array, write decode and read muxes inline).

Verification
REQ-026 reset = 0, any addresses -> data_out1 = data_out2 = 0 without any clock edge.
REQ-027 reset = 1, write_enable = 1, WA = 10, data_in = 0x03, one rising edge, RA1 = 10 -> data_out1 = 0x03; RA2 = 2 -> data_out2 = 0.
REQ-028 write_enable = 0, WA = 12, data_in = 0x24, edge, RA1 = 12 -> data_out1 = 0 (no write).
REQ-029 write 0xF1 to WA = 15, then RA1 = RA2 = 15 -> both outputs 0xF1; RA1 = 10 still 0x03.
REQ-030 RA1 = WA = 5, write 0xAA: before edge data_out1 = old value (0), after edge 0xAA.
REQ-031 After writes, drive reset = 0 between edges -> outputs go 0 immediately; release reset, all registers read 0.
